rect_hit_test: RTL and testbench

Per-pixel rectangle hit-test stage of the read GPU. It fetches the rectangle table from GPU-visible memory once per frame into a shadow register set and commits it atomically. It then compares each incoming pixel coordinate against every active rectangle and produces the `RECT_COUNT`-bit hit-flag vector. That vector feeds the binary-tree priority mux, which picks the highest-index hit.

---
 rtl/rect_hit_test_pkg.sv | 30 +++
 rtl/rect_hit_cmp.sv | 29 ++
 rtl/rect_hit_test.sv | 161 ++++++++++++++++
 tb/tb_rect_hit_test.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rect_hit_test_pkg.sv
// Shared constants, record layout and FSM encoding for the rectangle hit-test stage.
package rect_hit_test_pkg;

    localparam int RECT_COUNT       = 8;
    localparam int RECT_COUNT_WIDTH = $clog2(RECT_COUNT);
    localparam int RECT_FIELDS      = 5;

    // Word offsets inside one rectangle record in memory.
    localparam int RECT_X     = 0;
    localparam int RECT_Y     = 1;
    localparam int RECT_W     = 2;
    localparam int RECT_H     = 3;
    localparam int RECT_COLOR = 4;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic        [15:0] w;
        logic        [15:0] h;
        logic        [15:0] color;
    } rect_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_COMMIT
    } fetch_state_t;

endpackage

// File: rtl/rect_hit_cmp.sv
// Combinational containment check of one pixel against one rectangle.
module rect_hit_cmp
    import rect_hit_test_pkg::*;
(
    input  rect_t              rect,
    input  logic signed [15:0] px,
    input  logic signed [15:0] py,
    output logic               hit
);

    // Two extra bits so x + w (and y + h) can never wrap, even for the
    // largest positive origin with the largest extent.
    logic signed [17:0] x_lo, x_hi, y_lo, y_hi, px_e, py_e;

    assign x_lo = {{2{rect.x[15]}}, rect.x};
    assign y_lo = {{2{rect.y[15]}}, rect.y};
    assign x_hi = x_lo + $signed({2'b00, rect.w});
    assign y_hi = y_lo + $signed({2'b00, rect.h});
    assign px_e = {{2{px[15]}}, px};
    assign py_e = {{2{py[15]}}, py};

    // Half-open interval test on both axes; empty rects never hit.
    always_comb begin
        hit = (rect.w != 16'd0) && (rect.h != 16'd0) &&
              (px_e >= x_lo) && (px_e < x_hi) &&
              (py_e >= y_lo) && (py_e < y_hi);
    end

endmodule

// File: rtl/rect_hit_test.sv
// Rectangle table fetch (shadow + atomic commit) and 2-stage per-pixel hit test.
module rect_hit_test #(
    parameter int                    RECT_COUNT  = rect_hit_test_pkg::RECT_COUNT,
    parameter int                    RECT_FIELDS = rect_hit_test_pkg::RECT_FIELDS,
    parameter int                    ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_start,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    input  logic [15:0]                mem_rdata,
    output logic                       load_busy,
    output logic                       load_done,
    input  logic                       pix_valid,
    input  logic [15:0]                pix_x,
    input  logic [15:0]                pix_y,
    output logic                       hit_valid,
    output logic [RECT_COUNT-1:0]      hit_flags,
    output logic [16*RECT_COUNT-1:0]   rect_color
);
    import rect_hit_test_pkg::*;

    localparam int RW = (RECT_COUNT  > 1) ? $clog2(RECT_COUNT)  : 1;
    localparam int FW = (RECT_FIELDS > 1) ? $clog2(RECT_FIELDS) : 1;

    fetch_state_t      state, state_nxt;
    logic              start, last;
    logic [RW-1:0]     rect_idx, wr_rect;
    logic [FW-1:0]     field_idx, wr_field;
    logic              wr_vld;

    rect_t             shadow [RECT_COUNT];
    rect_t             active [RECT_COUNT];
    rect_t             s1_rect [RECT_COUNT];
    logic              s1_valid;
    logic signed [15:0] s1_x, s1_y;
    logic [RECT_COUNT-1:0] hits;

    // A start pulse landing in the commit cycle is dropped so the commit stays whole.
    assign start = load_start && (state != ST_COMMIT);
    assign last  = (rect_idx == RW'(RECT_COUNT - 1)) && (field_idx == FW'(RECT_FIELDS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: restart from any busy state except commit.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_FETCH;
            ST_FETCH:  if (start) state_nxt = ST_FETCH;
                       else if (last) state_nxt = ST_DRAIN;
            ST_DRAIN:  state_nxt = start ? ST_FETCH : ST_COMMIT;
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        load_busy = (state != ST_IDLE);
        load_done = (state == ST_COMMIT);
    end

    // Address/counter walk; the (rect, field) pair is delayed one cycle to match read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= BASE_ADDR;
            rect_idx  <= '0;
            field_idx <= '0;
            wr_vld    <= 1'b0;
            wr_rect   <= '0;
            wr_field  <= '0;
        end else begin
            wr_vld   <= (state == ST_FETCH) && !start;
            wr_rect  <= rect_idx;
            wr_field <= field_idx;
            if (start) begin
                mem_addr  <= BASE_ADDR;
                rect_idx  <= '0;
                field_idx <= '0;
            end else if (state == ST_FETCH && !last) begin
                mem_addr <= mem_addr + 1'b1;
                if (field_idx == FW'(RECT_FIELDS - 1)) begin
                    field_idx <= '0;
                    rect_idx  <= rect_idx + 1'b1;
                end else begin
                    field_idx <= field_idx + 1'b1;
                end
            end
        end
    end

    // Shadow table fill from returning read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RECT_COUNT; i++) shadow[i] <= '0;
        end else if (wr_vld) begin
            case (wr_field)
                FW'(RECT_X):     shadow[wr_rect].x     <= mem_rdata;
                FW'(RECT_Y):     shadow[wr_rect].y     <= mem_rdata;
                FW'(RECT_W):     shadow[wr_rect].w     <= mem_rdata;
                FW'(RECT_H):     shadow[wr_rect].h     <= mem_rdata;
                FW'(RECT_COLOR): shadow[wr_rect].color <= mem_rdata;
                default: ;
            endcase
        end
    end

    // Whole-table commit at the end of the commit cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RECT_COUNT; i++) active[i] <= '0;
        end else if (state == ST_COMMIT) begin
            for (int i = 0; i < RECT_COUNT; i++) active[i] <= shadow[i];
        end
    end

    // Stage 1: coordinates plus a snapshot of the active table, so a pixel never straddles a commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            for (int i = 0; i < RECT_COUNT; i++) s1_rect[i] <= '0;
        end else begin
            s1_valid <= pix_valid;
            if (pix_valid) begin
                s1_x <= pix_x;
                s1_y <= pix_y;
                for (int i = 0; i < RECT_COUNT; i++) s1_rect[i] <= active[i];
            end
        end
    end

    for (genvar g = 0; g < RECT_COUNT; g++) begin : g_rect
        rect_hit_cmp u_cmp (
            .rect (s1_rect[g]),
            .px   (s1_x),
            .py   (s1_y),
            .hit  (hits[g])
        );
        assign rect_color[16*g +: 16] = active[g].color;
    end

    // Stage 2: registered hit vector, forced to zero on bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_valid <= 1'b0;
            hit_flags <= '0;
        end else begin
            hit_valid <= s1_valid;
            hit_flags <= s1_valid ? hits : '0;
        end
    end

endmodule

// File: tb/tb_rect_hit_test.sv
// Self-checking bench for rect_hit_test: vector tables, fetch timing, restart, commit atomicity.
module tb_rect_hit_test;

    localparam int N       = rect_hit_test_pkg::RECT_COUNT;
    localparam int W       = 16 * N;
    localparam int FETCH_N = 5 * N;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            load_start = 1'b0;
    logic [15:0]     mem_addr;
    logic [15:0]     mem_rdata;
    logic            load_busy, load_done;
    logic            pix_valid = 1'b0;
    logic [15:0]     pix_x = '0, pix_y = '0;
    logic            hit_valid;
    logic [N-1:0]    hit_flags;
    logic [W-1:0]    rect_color;

    rect_hit_test dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .hit_valid  (hit_valid),
        .hit_flags  (hit_flags),
        .rect_color (rect_color)
    );

    always #5 clk = ~clk;

    // Word-addressed memory with one cycle of read latency.
    logic [15:0] mem [0:63];
    always @(posedge clk) mem_rdata <= mem[mem_addr[5:0]];

    typedef struct { int x; int y; int w; int h; logic [15:0] c; } brect_t;
    typedef struct { int x; int y; logic [N-1:0] e; } vec_t;

    brect_t       model_active [N];
    brect_t       pending [N];
    brect_t       tbl_next [N];
    logic [N-1:0] exp_q [$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] model_hits(input int px, input int py);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (model_active[i].w > 0 && model_active[i].h > 0 &&
                px >= model_active[i].x && px < model_active[i].x + model_active[i].w &&
                py >= model_active[i].y && py < model_active[i].y + model_active[i].h)
                r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] colvec();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[16*i +: 16] = model_active[i].c;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle_pix(input bit v, input int x, input int y, input logic [N-1:0] e);
        pix_valid = v;
        pix_x = 16'(x);
        pix_y = 16'(y);
        if (v) exp_q.push_back(e);
        tick();
    endtask

    task automatic slot(input bit stream);
        int x, y;
        if (stream) begin
            x = int'($urandom_range(48)) - 8;
            y = int'($urandom_range(48)) - 8;
            cycle_pix(1'b1, x, y, model_hits(x, y));
        end else begin
            cycle_pix(1'b0, 0, 0, '0);
        end
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < N; i++) tbl_next[i] = '{0, 0, 0, 0, 16'h0};
    endtask

    task automatic set_rect(input int i, input int x, input int y, input int w, input int h,
                            input logic [15:0] c);
        tbl_next[i] = '{x, y, w, h, c};
    endtask

    task automatic write_mem();
        for (int i = 0; i < N; i++) begin
            mem[5*i + 0] = 16'(tbl_next[i].x);
            mem[5*i + 1] = 16'(tbl_next[i].y);
            mem[5*i + 2] = 16'(tbl_next[i].w);
            mem[5*i + 3] = 16'(tbl_next[i].h);
            mem[5*i + 4] = tbl_next[i].c;
        end
        pending = tbl_next;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        load_start = 1'b0;
        pix_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) model_active[i] = '{0, 0, 0, 0, 16'h0};
        exp_q.delete();
    endtask

    task automatic drain_check(input string name);
        repeat (3) slot(1'b0);
        chk(name, W'(exp_q.size()), W'(0));
    endtask

    // Full load with cycle-exact timing checks; optional restart and commit-cycle poke.
    task automatic do_load(input int restart_at, input bit stream, input bit poke_commit);
        int T, k, done_cnt, done_at, addr_bad, busy_bad;
        bit restarted;
        write_mem();
        T = cyc;
        load_start = 1'b1;
        slot(stream);
        load_start = 1'b0;
        done_cnt = 0; done_at = -1; addr_bad = 0; busy_bad = 0; restarted = 0;
        for (int g = 0; g < 4 * FETCH_N + 20; g++) begin
            k = cyc - T;
            if (k >= 1 && k <= FETCH_N && mem_addr !== 16'(k - 1)) addr_bad++;
            if (load_busy !== (k >= 1 && k <= FETCH_N + 2)) busy_bad++;
            if (load_done === 1'b1) begin done_cnt++; done_at = k; end
            if (restart_at > 0 && !restarted && k == restart_at) begin
                chk("restart_old_addr", W'(mem_addr), W'(restart_at - 1));
                chk("restart_old_colors", rect_color, colvec());
                restarted = 1;
                T = cyc;
                load_start = 1'b1;
                slot(stream);
                load_start = 1'b0;
                chk("restart_addr_base", W'(mem_addr), W'(0));
            end else if (k >= FETCH_N + 3) begin
                break;
            end else begin
                if (poke_commit && k == FETCH_N + 2) load_start = 1'b1;
                slot(stream);
                load_start = 1'b0;
            end
        end
        chk("load_done_count", W'(done_cnt), W'(1));
        chk("load_done_cycle", W'(done_at), W'(FETCH_N + 2));
        chk("mem_addr_sweep_errs", W'(addr_bad), W'(0));
        chk("load_busy_window_errs", W'(busy_bad), W'(0));
        chk("rect_color_after_commit", rect_color, colvec());
        if (poke_commit) begin
            repeat (3) slot(1'b0);
            chk("commit_start_ignored", W'(load_busy), W'(0));
        end
        drain_check("scoreboard_empty_after_load");
    endtask

    // Output monitor: pops the scoreboard on every valid result; tracks commits.
    initial begin
        logic [N-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (hit_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL hit_unexpected actual=hit_valid(flags=%0h) required=no_result", hit_flags);
                    end else begin
                        e = exp_q.pop_front();
                        chk("hit_flags", W'(hit_flags), W'(e));
                    end
                end else begin
                    chk("hit_flags_idle_zero", W'(hit_flags), W'(0));
                end
                if (load_done === 1'b1) model_active = pending;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t va [6];
        vec_t vb [9];
        va[0] = '{10, 20, 8'h01}; va[1] = '{14, 22, 8'h01}; va[2] = '{15, 20, 8'h00};
        va[3] = '{10, 23, 8'h00}; va[4] = '{9, 20, 8'h00};  va[5] = '{14, 19, 8'h00};
        vb[0] = '{1, 1, 8'h88};      vb[1] = '{-4, -4, 8'h08}; vb[2] = '{32767, 0, 8'h20};
        vb[3] = '{-32768, 0, 8'h00}; vb[4] = '{32767, 1, 8'h00}; vb[5] = '{3, 3, 8'h08};
        vb[6] = '{2, 2, 8'h08};      vb[7] = '{4, 0, 8'h00};     vb[8] = '{0, 0, 8'h88};

        for (int i = 0; i < 64; i++) mem[i] = 16'h0;

        // Reset state.
        apply_reset();
        chk("reset_mem_addr", W'(mem_addr), W'(0));
        chk("reset_load_busy", W'(load_busy), W'(0));
        chk("reset_load_done", W'(load_done), W'(0));
        chk("reset_hit_valid", W'(hit_valid), W'(0));
        chk("reset_hit_flags", W'(hit_flags), W'(0));
        chk("reset_rect_color", rect_color, W'(0));
        cycle_pix(1'b1, 0, 0, 8'h00);
        cycle_pix(1'b1, 100, 100, 8'h00);
        drain_check("scoreboard_empty_no_load");

        // Table A: single rect, plain edges.
        clear_tbl();
        set_rect(0, 10, 20, 5, 3, 16'hF800);
        do_load(0, 1'b0, 1'b0);
        chk("rect_color0_F800", W'(rect_color[15:0]), W'(16'hF800));
        for (int i = 0; i < 6; i++) cycle_pix(1'b1, va[i].x, va[i].y, va[i].e);
        drain_check("scoreboard_empty_vec_a");

        // Table B: overlap, negative origin, no wrap at +32767; streamed across commit.
        clear_tbl();
        set_rect(3, -4, -4, 8, 8, 16'h07E0);
        set_rect(5, 32767, 0, 2, 1, 16'h001F);
        set_rect(7, 0, 0, 2, 2, 16'hFFFF);
        do_load(0, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) cycle_pix(1'b1, vb[i].x, vb[i].y, vb[i].e);
        drain_check("scoreboard_empty_vec_b");

        // Table C: restart 7 cycles in, old table stays live until the single commit.
        clear_tbl();
        set_rect(0, 0, 0, 20, 20, 16'h1111);
        set_rect(3, -4, -4, 8, 8, 16'h2222);
        set_rect(6, 5, 5, 30, 3, 16'h3333);
        do_load(7, 1'b1, 1'b0);
        cycle_pix(1'b1, 1, 1, 8'h09);
        drain_check("scoreboard_empty_vec_c");

        // Reset in the middle of a fetch clears the active table.
        clear_tbl();
        set_rect(0, 10, 20, 5, 3, 16'hF800);
        write_mem();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        repeat (10) tick();
        apply_reset();
        chk("midreset_rect_color", rect_color, W'(0));
        chk("midreset_load_busy", W'(load_busy), W'(0));
        chk("midreset_mem_addr", W'(mem_addr), W'(0));
        cycle_pix(1'b1, 1, 1, 8'h00);
        drain_check("scoreboard_empty_midreset");
        repeat (3) tick();
        chk("midreset_no_done", W'(load_done), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
